mc_alu: RTL and testbench

MC_ALU -- requirements
Module: mc_alu

---
 rtl/mc_alu_pkg.sv | 58 +++++
 rtl/mc_alu_mul_iter_32.sv | 48 ++++
 rtl/mc_alu.sv | 97 +++++++++
 tb/tb_mc_alu.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states, the
// multiply iteration count and the single-cycle ALU function.
package mc_alu_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MUL_ITERS = 32;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_NOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_MULU = 4'b1000
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_MUL,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              ovf;
  } alu_out_t;

  // MULU is handled by the iterative datapath, so it falls to the default here
  function automatic alu_out_t alu_calc(input logic [3:0] op,
                                        input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
    alu_out_t o;
    o = '0;
    case (op)
      OP_AND: o.res = a & b;
      OP_OR:  o.res = a | b;
      OP_ADD: begin
        o.res = a + b;
        o.ovf = (a[DATA_W-1] == b[DATA_W-1]) && (o.res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_XOR: o.res = a ^ b;
      OP_NOR: o.res = ~(a | b);
      OP_SRL: o.res = b >> a[4:0];
      OP_SUB: begin
        o.res = a - b;
        o.ovf = (a[DATA_W-1] != b[DATA_W-1]) && (o.res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SLT: o.res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mc_alu_mul_iter_32.sv
// Shift-add unsigned multiplier, one partial product per step; low 32 bits only.
module mul_iter_32
  import mc_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] prod,
  output logic              last
);

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [5:0]        r_cnt;

  logic [DATA_W-1:0] w_addend;
  logic [DATA_W-1:0] w_sum;

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_sum    = r_acc + w_addend;
  // prod is the post-step accumulator so the final step's result can be captured on the same edge
  assign prod     = w_sum;
  assign last     = step && (r_cnt == 6'(MUL_ITERS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (load) begin
      r_mcand  <= A;
      r_mplier <= B;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (step) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 6'd1;
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus a 32-step iterative MULU,
// with registered result/flags and a one-cycle done pulse.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_operation,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  state_e     r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;

  logic             w_accept;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [WIDTH-1:0] w_prod;
  alu_out_t         w_calc;

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_load   = w_accept && (ALU_operation == OP_MULU);
  assign w_step   = (r_state == ST_MUL);
  assign w_calc   = alu_calc(r_op, r_a, r_b);

  mul_iter_32 u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .step (w_step),
    .A    (A),
    .B    (B),
    .prod (w_prod),
    .last (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      res      <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= ALU_operation;
            busy    <= 1'b1;
            r_state <= (ALU_operation == OP_MULU) ? ST_MUL : ST_CALC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          res      <= w_calc.res;
          zero     <= ~|w_calc.res;
          overflow <= w_calc.ovf;
          busy     <= 1'b0;
          done     <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_MUL: begin
          if (w_last) begin
            res      <= w_prod;
            zero     <= ~|w_prod;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Scoreboard-based bench for mc_alu: expected results are queued at issue and
// checked when done pulses.
module tb_mc_alu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_operation;
  logic [31:0] res;
  logic        zero;
  logic        overflow;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  mc_alu #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .A             (A),
    .B             (B),
    .ALU_operation (ALU_operation),
    .res           (res),
    .zero          (zero),
    .overflow      (overflow),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [32:0] s;
    logic [63:0] p;
    e.res = 32'h0;
    e.ovf = 1'b0;
    e.lat = 1;
    case (op)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: begin s = {a[31], a} + {b[31], b}; e.res = s[31:0]; e.ovf = s[32] ^ s[31]; end
      4'd3: e.res = a ^ b;
      4'd4: e.res = ~(a | b);
      4'd5: e.res = b >> a[4:0];
      4'd6: begin s = {a[31], a} - {b[31], b}; e.res = s[31:0]; e.ovf = s[32] ^ s[31]; end
      4'd7: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: begin p = {32'h0, a} * {32'h0, b}; e.res = p[31:0]; e.lat = 32; end
      default: e.res = 32'h0;
    endcase
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    ALU_operation = op;
    A = a;
    B = b;
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cycles, output logic timed_out);
    lat = 0;
    busy_cycles = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    ALU_operation = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (res !== 32'h0) begin failures++; $display("FAIL reset_res got=%h exp=%h", res, 32'h0); end
    checks++;
    if ({zero, overflow, busy, done} !== 4'b1000) begin
      failures++; $display("FAIL reset_flags got=%b exp=%b", {zero, overflow, busy, done}, 4'b1000);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    exp_t e; int lat; int bc; logic to;
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL add_busy got=%b exp=1", busy); end
    wait_done(lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to !== 1'b0 || lat != e.lat) begin failures++; $display("FAIL add_latency got=%0d exp=%0d", lat, e.lat); end
    checks++;
    if ({res, zero, overflow} !== {e.res, e.zero, e.ovf}) begin
      failures++; $display("FAIL add_result got=%h z=%b o=%b exp=%h z=%b o=%b", res, zero, overflow, e.res, e.zero, e.ovf);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00 || res !== e.res) begin
      failures++; $display("FAIL add_hold got=done%b busy%b res=%h exp=done0 busy0 res=%h", done, busy, res, e.res);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e; int lat; int bc; logic to;
    issue(4'b0110, 32'd5, 32'd5);
    wait_done(lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to !== 1'b0 || {res, zero, overflow} !== {e.res, e.zero, e.ovf}) begin
      failures++; $display("FAIL sub_result got=%h z=%b o=%b exp=%h z=%b o=%b", res, zero, overflow, e.res, e.zero, e.ovf);
    end
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1);
    checks++;
    if ({busy, done} !== 2'b10) begin failures++; $display("FAIL b2b_accept got=busy%b done%b exp=busy1 done0", busy, done); end
    wait_done(lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to !== 1'b0 || lat != e.lat || {res, zero, overflow} !== {e.res, e.zero, e.ovf}) begin
      failures++; $display("FAIL slt_result got=%h lat=%0d exp=%h lat=%0d", res, lat, e.res, e.lat);
    end
  endtask

  task automatic test_mulu;
    exp_t e; int lat; int bc; logic to;
    issue(4'b1000, 32'h0001_0001, 32'h0001_0001);
    wait_done(lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to !== 1'b0 || lat != e.lat) begin failures++; $display("FAIL mul_latency got=%0d exp=%0d", lat, e.lat); end
    checks++;
    if (bc != 32) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=%0d", bc, 32); end
    checks++;
    if ({res, zero, overflow} !== {e.res, e.zero, e.ovf}) begin
      failures++; $display("FAIL mul_result got=%h exp=%h", res, e.res);
    end
  endtask

  task automatic test_start_ignored;
    exp_t e; int lat; int bc; logic to;
    issue(4'b1000, 32'd3, 32'd5);
    start = 1'b1;
    A = 32'd7;
    B = 32'd9;
    ALU_operation = 4'b0010;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b10) begin failures++; $display("FAIL ignore_busy got=busy%b done%b exp=busy1 done0", busy, done); end
    start = 1'b0;
    wait_done(lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to !== 1'b0 || lat + 10 != e.lat || res !== e.res) begin
      failures++; $display("FAIL ignore_result got=%h lat=%0d exp=%h lat=%0d", res, lat + 10, e.res, e.lat);
    end
  endtask

  task automatic test_reset_mid_mul;
    exp_t e; int done_seen;
    issue(4'b1000, 32'h0000_1234, 32'h10);
    e = sb.pop_front();
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({res, zero, busy, done} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL mid_reset got=%h z=%b b=%b d=%b exp=%h z=1 b=0 d=0", res, zero, busy, done, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    checks++;
    if (done_seen != 0 || e.res == res) begin
      failures++; $display("FAIL mid_reset_no_done got=%0d res=%h exp=0 res=%h", done_seen, res, 32'h0);
    end
  endtask

  task automatic test_srl_undef;
    exp_t e; int lat; int bc; logic to;
    issue(4'b0101, 32'd4, 32'h8000_0000);
    wait_done(lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to !== 1'b0 || res !== e.res) begin failures++; $display("FAIL srl_result got=%h exp=%h", res, e.res); end
    issue(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_done(lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to !== 1'b0 || lat != e.lat || {res, zero, overflow} !== {e.res, e.zero, e.ovf}) begin
      failures++; $display("FAIL undef_result got=%h z=%b o=%b exp=%h z=%b o=%b", res, zero, overflow, e.res, e.zero, e.ovf);
    end
  endtask

  task automatic test_random;
    exp_t e; int lat; int bc; logic to;
    logic [31:0] a; logic [31:0] b; logic [3:0] op;
    for (int n = 0; n < 24; n++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom();
      b = (n % 4 == 0) ? a : $urandom();
      issue(op, a, b);
      wait_done(lat, bc, to);
      e = sb.pop_front();
      checks++;
      if (to !== 1'b0 || lat != e.lat || {res, zero, overflow} !== {e.res, e.zero, e.ovf}) begin
        failures++;
        $display("FAIL rand_%0d op=%h a=%h b=%h got=%h z=%b o=%b lat=%0d exp=%h z=%b o=%b lat=%0d",
                 n, op, a, b, res, zero, overflow, lat, e.res, e.zero, e.ovf, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mulu();
    test_start_ignored();
    test_reset_mid_mul();
    test_srl_undef();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
